// File: rtl/fb_arbiter.sv
// fb_arbiter: round-robin arbiter that shares one flushbuffer among NREQ consumers.
// The winner's flush length drives fb_N; the ld_bfr/incnt snapshot returns with its ack.
module fb_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_n,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      grant,
  output logic [31:0]          resp_ld_bfr,
  output logic [31:0]          resp_incnt,
  output logic                 err,
  output logic [31:0]          fb_N,
  output logic                 fb_in_valid,
  input  logic                 fb_done,
  input  logic [31:0]          ld_bfr,
  input  logic [31:0]          incnt
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_e;

  state_e           state_q,    state_d;
  logic [NREQ-1:0]  grant_q,    grant_d;
  logic [NREQ-1:0]  ack_q,      ack_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      fb_n_q,     fb_n_d;
  logic [31:0]      resp_ld_q,  resp_ld_d;
  logic [31:0]      resp_inc_q, resp_inc_d;
  logic             fb_valid_q, fb_valid_d;
  logic             err_q,      err_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[IDX_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    fb_n_d     = fb_n_q;
    fb_valid_d = fb_valid_q;
    resp_ld_d  = resp_ld_q;
    resp_inc_d = resp_inc_q;
    ack_d      = '0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = BUSY;
          owner_d    = win_idx;
          grant_d    = NREQ'(1) << win_idx;
          fb_n_d     = req_n[32*win_idx +: 32];
          fb_valid_d = 1'b1;
          wait_cnt_d = '0;
        end
      end
      BUSY: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A done seen in the first BUSY cycle is left over from the previous flush.
        if (fb_done && (wait_cnt_q != '0)) begin
          resp_ld_d  = ld_bfr;
          resp_inc_d = incnt;
          ack_d      = grant_q;
          grant_d    = '0;
          fb_valid_d = 1'b0;
          state_d    = DRAIN;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ack_d      = grant_q;
          err_d      = 1'b1;
          grant_d    = '0;
          fb_valid_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        rr_ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      fb_n_q     <= '0;
      fb_valid_q <= 1'b0;
      resp_ld_q  <= '0;
      resp_inc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      fb_n_q     <= fb_n_d;
      fb_valid_q <= fb_valid_d;
      resp_ld_q  <= resp_ld_d;
      resp_inc_q <= resp_inc_d;
      err_q      <= err_d;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign err         = err_q;
  assign fb_N        = fb_n_q;
  assign fb_in_valid = fb_valid_q;
  assign resp_ld_bfr = resp_ld_q;
  assign resp_incnt  = resp_inc_q;

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Round-robin arbiter sharing one flushbuffer instance among NREQ bitstream consumers (h/v motion-code fetch, residual fetch, dmvector fetch).
- Each consumer requests a flush of N bits. The arbiter drives the flushbuffer's N/in_valid inputs, waits for done, and returns the captured ld_bfr/incnt snapshot to the winner.
- Sits between the motion-vector sequencing logic and the flushbuffer. Removes per-stage fb_N/fb_in_valid muxing from the top level.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles to wait for fb_done before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NREQ  per-requester request level, held until matching ack
req_n  in  NREQ*32  flat flush lengths; requester i uses bits [32*i+31:32*i]
ack  out  NREQ  one-cycle pulse to granted requester; response valid
grant  out  NREQ  one-hot owner of the flushbuffer, 0 when idle
resp_ld_bfr  out  32  ld_bfr captured at completion
resp_incnt  out  32  signed incnt captured at completion
err  out  1  one-cycle pulse with ack when the transaction timed out
fb_N  out  32  flushbuffer N
fb_in_valid  out  1  flushbuffer in_valid
fb_done  in  1  flushbuffer done
ld_bfr  in  32  flushbuffer ld_bfr
incnt  in  32  flushbuffer incnt (signed)

Behaviour:
- Reset (rst high at posedge, any state) clears the following and aborts any transaction with no ack:
  - state=IDLE, grant=0, ack=0, err=0, fb_in_valid=0, fb_N=0
  - resp_ld_bfr=0, resp_incnt=0, wait_cnt=0, rr_ptr=0
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - If any req bit is set, choose winner w = first set bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Next cycle: grant=onehot(w), fb_N=req_n[w], fb_in_valid=1, wait_cnt=0, state=BUSY.
  - Latency from req to fb_in_valid: 1 cycle.
- BUSY:
  - fb_in_valid stays 1. fb_N and grant stay constant; a req_n change mid-transaction is ignored.
  - wait_cnt increments every cycle.
  - fb_done is ignored while wait_cnt==0, so a stale done from the previous transaction cannot complete this one.
  - When fb_done=1 and wait_cnt>=1:
    - latch resp_ld_bfr=ld_bfr and resp_incnt=incnt
    - ack[w]=1 for one cycle, fb_in_valid=0, state=DRAIN
  - The ack and response registers update on the same edge; data is valid while ack is high and holds until the next completion.
  - Timeout: if wait_cnt reaches TIMEOUT-1 without done, ack[w]=1 and err=1 on the next edge. Response registers are unchanged. fb_in_valid=0, state=DRAIN.
  - A requester dropping req while granted is ignored; the transaction completes and ack is still issued.
- DRAIN:
  - One cycle with grant=0 and fb_in_valid=0, letting fb_done fall.
  - rr_ptr=(w+1) mod NREQ, state=IDLE.
  - Back-to-back throughput: one transaction per (flush latency + 2) cycles.
- Requesters must deassert req the cycle after ack. A req still high in IDLE is a new request.
- N=0 is legal and passed through unchanged; the flushbuffer returns the current state.
- Simultaneous requests: exactly one grant. No requester waits more than NREQ-1 transactions.
- ack, err and grant are registered outputs. fb_N and fb_in_valid are registered.

Test Plan:
- Single request: reset; req=0001, req_n[0]=12; fb model asserts done 3 cycles after in_valid with ld_bfr=32'h0068_7830, incnt=24.
  - Expect fb_N=12 and fb_in_valid one cycle after req.
  - Expect ack=0001 with resp_ld_bfr=32'h00687830 and resp_incnt=24, then one DRAIN cycle, then IDLE.
- Round-robin fairness: req=1111 held, each re-raised after ack, req_n[i]=i+1. Expect grants in order 0,1,2,3,0 and fb_N sequence 1,2,3,4,1.
- Stale done: fb_done held high from before the grant. Expect it ignored in the first BUSY cycle and ack on the second BUSY cycle's edge, not earlier.
- Timeout: TIMEOUT=8, fb_done never asserted. Expect ack=err=1 exactly 8 cycles after fb_in_valid rose, responses unchanged, next requester then served.
- Reset mid-transaction: assert rst in BUSY. Expect grant=0, fb_in_valid=0 and no ack next cycle; a following req=0100 is granted to requester 2 (rr_ptr=0 scan).
- Withdrawal: requester 1 drops req in BUSY. Expect the transaction to finish with ack[1]=1, and requester 1 not re-granted.
